// File: rtl/tau_timer_pkg.sv
// Shared types and default sizes for the programmable down-count timer.
package tau_timer_pkg;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_PS_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } timer_state_t;

endpackage

// File: rtl/counter_loadable.sv
// Loadable up/down counter; load has priority over counting, all gated by enable.
module counter_loadable #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             count_up,
    input  logic             count_down,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count_value
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_value <= '0;
        end else if (enable) begin
            if (load) begin
                count_value <= load_value;
            end else if (count_up) begin
                count_value <= count_value + 1'b1;
            end else if (count_down) begin
                count_value <= count_value - 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_controller.sv
// Sequences a counter_loadable as a prescaled one-shot/periodic down-count timer
// with a sticky expiry interrupt.
module timer_controller
    import tau_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PS_WIDTH = DEF_PS_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                periodic,
    input  logic [WIDTH-1:0]    reload_value,
    input  logic [PS_WIDTH-1:0] prescale,
    input  logic                irq_ack,
    output logic                busy,
    output logic                expired_irq,
    output logic [WIDTH-1:0]    count_value
);

    timer_state_t        state;
    logic [PS_WIDTH-1:0] prescaler;
    logic [PS_WIDTH-1:0] ps_latched;

    logic tick;
    logic at_zero;
    logic ctl_load;
    logic ctl_down;
    logic ctl_enable;
    logic expire;

    // A start or stop pulse pre-empts whatever RUN would have done this cycle.
    always_comb begin
        tick       = (state == RUN) && (prescaler == ps_latched);
        at_zero    = (count_value == '0);
        ctl_load   = (state == LOAD) && !stop;
        ctl_down   = tick && !at_zero && !stop && !start;
        expire     = tick && at_zero && !stop && !start;
        ctl_enable = ctl_load || ctl_down;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prescaler   <= '0;
            ps_latched  <= '0;
            busy        <= 1'b0;
            expired_irq <= 1'b0;
        end else begin
            if (expire) begin
                expired_irq <= 1'b1;
            end else if (irq_ack) begin
                expired_irq <= 1'b0;
            end

            if (stop) begin
                state     <= IDLE;
                prescaler <= '0;
                busy      <= 1'b0;
            end else if (start) begin
                state <= LOAD;
                busy  <= 1'b1;
            end else begin
                case (state)
                    LOAD: begin
                        state      <= RUN;
                        prescaler  <= '0;
                        ps_latched <= prescale;
                    end
                    RUN: begin
                        if (tick) begin
                            prescaler <= '0;
                            if (at_zero) begin
                                state <= periodic ? LOAD : IDLE;
                                busy  <= periodic;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    counter_loadable #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .enable     (ctl_enable),
        .load       (ctl_load),
        .count_up   (1'b0),
        .count_down (ctl_down),
        .load_value (reload_value),
        .count_value(count_value)
    );

endmodule

// File: tb/tb_timer_controller.sv
// Scoreboard bench for timer_controller: expectations are queued with the cycle
// they fall due and compared as the DUT reaches that cycle.
module tb_timer_controller;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned PS_WIDTH = 4;
    localparam int SEL_COUNT = 0;
    localparam int SEL_IRQ   = 1;
    localparam int SEL_BUSY  = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                periodic = 1'b0;
    logic [WIDTH-1:0]    reload_value = '0;
    logic [PS_WIDTH-1:0] prescale = '0;
    logic                irq_ack = 1'b0;
    logic                busy;
    logic                expired_irq;
    logic [WIDTH-1:0]    count_value;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    typedef struct {
        string       tag;
        int unsigned due;
        int          sel;
        int          value;
    } exp_t;

    exp_t sb[$];

    timer_controller #(
        .WIDTH   (WIDTH),
        .PS_WIDTH(PS_WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .periodic    (periodic),
        .reload_value(reload_value),
        .prescale    (prescale),
        .irq_ack     (irq_ack),
        .busy        (busy),
        .expired_irq (expired_irq),
        .count_value (count_value)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_COUNT: return 32'(count_value);
            SEL_IRQ:   return {31'b0, expired_irq};
            default:   return {31'b0, busy};
        endcase
    endfunction

    task automatic expect_at(input string tag, input int unsigned due, input int sel, input int value);
        exp_t e;
        e.tag = tag;
        e.due = due;
        e.sel = sel;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t keep[$];
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                check(sb[i].tag, observe(sb[i].sel), sb[i].value);
            end else if (sb[i].due < cyc) begin
                check({sb[i].tag, "_missed"}, cyc, sb[i].due);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            drain();
        end
    endtask

    task automatic pulse_start(output int unsigned s);
        start = 1'b1;
        run_cycles(1);
        start = 1'b0;
        s = cyc;
    endtask

    task automatic cleanup();
        stop = 1'b1;
        irq_ack = 1'b1;
        run_cycles(1);
        stop = 1'b0;
        irq_ack = 1'b0;
        run_cycles(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int unsigned s;
        int unsigned s2;

        run_cycles(2);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_irq", {31'b0, expired_irq}, 0);
        check("rst_count", 32'(count_value), 0);
        reset = 1'b0;
        run_cycles(1);

        // 1. reset mid-operation
        reload_value = 8'd3; prescale = 4'd0; periodic = 1'b0;
        pulse_start(s);
        run_cycles(3);
        check("t1_count_pre", 32'(count_value), 1);
        #2 reset = 1'b1;
        #1;
        check("t1_rst_busy", {31'b0, busy}, 0);
        check("t1_rst_irq", {31'b0, expired_irq}, 0);
        check("t1_rst_count", 32'(count_value), 0);
        #1 reset = 1'b0;
        for (int k = 1; k <= 10; k++) expect_at("t1_no_irq", cyc + k, SEL_IRQ, 0);
        expect_at("t1_idle", cyc + 10, SEL_BUSY, 0);
        run_cycles(10);
        cleanup();

        // 2. one-shot R=3 P=0
        reload_value = 8'd3; prescale = 4'd0; periodic = 1'b0;
        pulse_start(s);
        check("t2_busy_load", {31'b0, busy}, 1);
        expect_at("t2_c3", s + 1, SEL_COUNT, 3);
        expect_at("t2_c2", s + 2, SEL_COUNT, 2);
        expect_at("t2_c1", s + 3, SEL_COUNT, 1);
        expect_at("t2_c0", s + 4, SEL_COUNT, 0);
        expect_at("t2_irq_early", s + 4, SEL_IRQ, 0);
        expect_at("t2_irq", s + 5, SEL_IRQ, 1);
        expect_at("t2_done", s + 5, SEL_BUSY, 0);
        expect_at("t2_nowrap", s + 6, SEL_COUNT, 0);
        expect_at("t2_hold", s + 8, SEL_COUNT, 0);
        expect_at("t2_irq_sticky", s + 8, SEL_IRQ, 1);
        run_cycles(8);
        cleanup();

        // 3. periodic R=2 P=1, interval 7, ack collides with 2nd expiry
        reload_value = 8'd2; prescale = 4'd1; periodic = 1'b1;
        pulse_start(s);
        expect_at("t3_c2", s + 1, SEL_COUNT, 2);
        expect_at("t3_c2_hold", s + 2, SEL_COUNT, 2);
        expect_at("t3_c1", s + 3, SEL_COUNT, 1);
        expect_at("t3_c0", s + 5, SEL_COUNT, 0);
        expect_at("t3_irq0_early", s + 6, SEL_IRQ, 0);
        expect_at("t3_irq1", s + 7, SEL_IRQ, 1);
        expect_at("t3_reload", s + 8, SEL_COUNT, 2);
        expect_at("t3_ack", s + 9, SEL_IRQ, 0);
        expect_at("t3_irq2_early", s + 13, SEL_IRQ, 0);
        expect_at("t3_irq2_set_wins", s + 14, SEL_IRQ, 1);
        expect_at("t3_busy", s + 14, SEL_BUSY, 1);
        run_cycles(8);
        irq_ack = 1'b1;
        run_cycles(1);
        irq_ack = 1'b0;
        run_cycles(4);
        irq_ack = 1'b1;
        run_cycles(1);
        irq_ack = 1'b0;
        cleanup();

        // 4. stop & start collide at count 5
        reload_value = 8'd8; prescale = 4'd0; periodic = 1'b0;
        pulse_start(s);
        run_cycles(4);
        check("t4_at5", 32'(count_value), 5);
        start = 1'b1; stop = 1'b1;
        run_cycles(1);
        start = 1'b0; stop = 1'b0;
        check("t4_stop_wins", {31'b0, busy}, 0);
        check("t4_frozen", 32'(count_value), 5);
        expect_at("t4_still5", cyc + 3, SEL_COUNT, 5);
        expect_at("t4_still_idle", cyc + 3, SEL_BUSY, 0);
        run_cycles(3);
        pulse_start(s2);
        expect_at("t4_reload", s2 + 1, SEL_COUNT, 8);
        expect_at("t4_running", s2 + 1, SEL_BUSY, 1);
        run_cycles(2);
        cleanup();

        // 5. zero reload R=0 P=3
        reload_value = 8'd0; prescale = 4'd3; periodic = 1'b0;
        pulse_start(s);
        for (int k = 1; k <= 8; k++) expect_at("t5_no_wrap", s + k, SEL_COUNT, 0);
        expect_at("t5_irq_early", s + 4, SEL_IRQ, 0);
        expect_at("t5_irq", s + 5, SEL_IRQ, 1);
        expect_at("t5_idle", s + 6, SEL_BUSY, 0);
        run_cycles(8);
        cleanup();

        // 6. restart mid-run with a new reload value
        reload_value = 8'd10; prescale = 4'd0; periodic = 1'b0;
        pulse_start(s);
        run_cycles(7);
        check("t6_at4", 32'(count_value), 4);
        reload_value = 8'h20;
        pulse_start(s2);
        expect_at("t6_reload", s2 + 1, SEL_COUNT, 32);
        expect_at("t6_busy", s2 + 1, SEL_BUSY, 1);
        expect_at("t6_count", s2 + 2, SEL_COUNT, 31);
        run_cycles(2);
        cleanup();

        check("sb_leftover", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
